// File: rtl/sobel_pkg.sv
// Shared types for the Sobel output framer: pixel, tagged pixel and framer FSM states.
package sobel_pkg;

    typedef logic [23:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   sof;
        logic   eol;
        logic   eof;
    } tagged_pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } framer_state_e;

endpackage

// File: rtl/sobel_out_framer_if.sv
// Pixel-in / tagged-pixel-out valid-ready bundle around the framer.
interface sobel_out_framer_if;

    sobel_pkg::pixel_t data_m_sobel;
    logic              valid_m;
    logic              ready_m;
    sobel_pkg::pixel_t data_s;
    logic              valid_s;
    logic              ready_s;
    logic              sof_s;
    logic              eol_s;
    logic              eof_s;

    modport master (
        output data_m_sobel, valid_m, ready_s,
        input  ready_m, data_s, valid_s, sof_s, eol_s, eof_s
    );

    modport slave (
        input  data_m_sobel, valid_m, ready_s,
        output ready_m, data_s, valid_s, sof_s, eol_s, eof_s
    );

endinterface

// File: rtl/sobel_skid_buf.sv
// 2-entry valid/ready skid buffer: output register plus one skid register.
// Latency 1 cycle; in_rdy_o is registered (!skid_full) so it never depends on out_rdy_i.
module sobel_skid_buf #(
    parameter type T = sobel_pkg::tagged_pix_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld_i,
    input  T     in_dat_i,
    output logic in_rdy_o,
    output logic out_vld_o,
    output T     out_dat_o,
    input  logic out_rdy_i
);

    T     out_q, out_d;
    T     skid_q, skid_d;
    logic out_vld_q, out_vld_d;
    logic skid_full_q, skid_full_d;
    logic xfer;

    assign xfer      = out_vld_q && out_rdy_i;
    assign in_rdy_o  = !skid_full_q;
    assign out_vld_o = out_vld_q;
    assign out_dat_o = out_q;

    always_comb begin
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (skid_full_q) begin
            if (xfer) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (in_vld_i) begin
            // Reload the output register directly whenever it is free this cycle.
            if (!out_vld_q || xfer) begin
                out_d     = in_dat_i;
                out_vld_d = 1'b1;
            end else begin
                skid_d      = in_dat_i;
                skid_full_d = 1'b1;
            end
        end else if (xfer) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_vld_q   <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_vld_q   <= out_vld_d;
            skid_full_q <= skid_full_d;
        end
    end

endmodule

// File: rtl/sobel_out_framer.sv
// Tags the Sobel edge-map stream with sof/eol/eof from raster position, counts edge pixels
// per frame, and forwards through a skid buffer (1-cycle latency, registered ready_m).
module sobel_out_framer
    import sobel_pkg::*;
#(
    parameter int     IMG_WIDTH  = 640,
    parameter int     IMG_HEIGHT = 480,
    parameter pixel_t EDGE_VALUE = 24'hFFFFFF,
    parameter int     CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    sobel_out_framer_if.slave   bus,
    output logic [CNT_W-1:0]    edge_count,
    output logic                stat_valid
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    framer_state_e    state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic             stat_valid_q, stat_valid_d;

    logic        buf_rdy;
    logic        accept;
    logic        is_edge;
    tagged_pix_t in_pix;
    tagged_pix_t out_pix;

    assign bus.ready_m = buf_rdy && (state_q != IDLE);
    assign accept      = bus.valid_m && bus.ready_m;
    assign is_edge     = (bus.data_m_sobel == EDGE_VALUE);

    always_comb begin
        in_pix.data = bus.data_m_sobel;
        in_pix.sof  = (col_q == '0) && (row_q == '0);
        in_pix.eol  = (col_q == COL_LAST);
        in_pix.eof  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (in_pix.eol) begin
                col_d = '0;
                row_d = in_pix.eof ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Stop decisions use the post-accept position so a pixel taken on the
    // same edge that enable falls is never the start of a truncated frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = (col_d == '0 && row_d == '0) ? IDLE : STOP;
            STOP:    if (accept && in_pix.eof) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d        = acc_q;
        edge_count_d = edge_count_q;
        stat_valid_d = 1'b0;
        if (accept) begin
            if (in_pix.eof) begin
                edge_count_d = acc_q + CNT_W'(is_edge);
                stat_valid_d = 1'b1;
                acc_d        = '0;
            end else begin
                acc_d = acc_q + CNT_W'(is_edge);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            edge_count_q <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            edge_count_q <= edge_count_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    sobel_skid_buf #(.T(tagged_pix_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (bus.valid_m && (state_q != IDLE)),
        .in_dat_i  (in_pix),
        .in_rdy_o  (buf_rdy),
        .out_vld_o (bus.valid_s),
        .out_dat_o (out_pix),
        .out_rdy_i (bus.ready_s)
    );

    assign bus.data_s  = out_pix.data;
    assign bus.sof_s   = out_pix.sof;
    assign bus.eol_s   = out_pix.eol;
    assign bus.eof_s   = out_pix.eof;
    assign edge_count  = edge_count_q;
    assign stat_valid  = stat_valid_q;

endmodule

// File: tb/tb_sobel_out_framer.sv
// Directed and randomised checks of sobel_out_framer on a 4x2 frame.
module tb_sobel_out_framer;
    import sobel_pkg::*;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [CNT_W-1:0] edge_count;
    logic             stat_valid;

    sobel_out_framer_if bus ();

    sobel_out_framer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .EDGE_VALUE (24'hFFFFFF),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .edge_count (edge_count),
        .stat_valid (stat_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stat_n = 0;
    tagged_pix_t rx_q[$];
    tagged_pix_t exp_q[$];
    logic [CNT_W-1:0] stat_q[$];
    logic [CNT_W-1:0] exp_ec_q[$];

    typedef struct {
        logic en; logic vm; pixel_t d; logic rs;
        logic rdy; logic vs; pixel_t dat; logic sof; logic eol; logic eof;
        logic stv; logic [CNT_W-1:0] ec;
    } vec_t;

    vec_t vecs[11];

    always @(posedge clk) begin
        if (!rst && bus.valid_s && bus.ready_s) begin
            tagged_pix_t t;
            t.data = bus.data_s;
            t.sof  = bus.sof_s;
            t.eol  = bus.eol_s;
            t.eof  = bus.eof_s;
            rx_q.push_back(t);
        end
        if (!rst && stat_valid) begin
            stat_n++;
            stat_q.push_back(edge_count);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Entered and left at a negedge; acc reports whether this cycle's pixel was taken.
    task automatic cyc(input logic en, input logic vm, input pixel_t d, input logic rs,
                       output logic acc);
        enable           = en;
        bus.valid_m      = vm;
        bus.data_m_sobel = d;
        bus.ready_s      = rs;
        acc              = vm && bus.ready_m;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic tagged_pix_t mkp(input pixel_t d, input int idx);
        int c;
        int r;
        c = idx % W;
        r = (idx / W) % H;
        mkp.data = d;
        mkp.sof  = (c == 0) && (r == 0);
        mkp.eol  = (c == W - 1);
        mkp.eof  = (c == W - 1) && (r == H - 1);
    endfunction

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_px%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    function automatic vec_t mkv(input logic en, vm, input pixel_t d, input logic rdy, vs,
                                 input pixel_t dat, input logic sof, eol, eof, stv,
                                 input logic [CNT_W-1:0] ec);
        mkv = '{en: en, vm: vm, d: d, rs: 1'b1, rdy: rdy, vs: vs, dat: dat,
                sof: sof, eol: eol, eof: eof, stv: stv, ec: ec};
    endfunction

    initial begin
        logic a;
        int   acc_n, c, cnt;
        logic vm, rs;
        pixel_t d;
        logic [CNT_W-1:0] edges;

        vecs[0]  = mkv(1, 0, 24'h0,      1, 0, 24'h0,      0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 1, 24'hFFFFFF, 1, 1, 24'hFFFFFF, 1, 0, 0, 0, 0);
        vecs[2]  = mkv(1, 1, 24'h000010, 1, 1, 24'h000010, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 1, 24'hFFFFFF, 1, 1, 24'hFFFFFF, 0, 0, 0, 0, 0);
        vecs[4]  = mkv(1, 1, 24'hFFFFFE, 1, 1, 24'hFFFFFE, 0, 1, 0, 0, 0);
        vecs[5]  = mkv(1, 1, 24'h000020, 1, 1, 24'h000020, 0, 0, 0, 0, 0);
        vecs[6]  = mkv(1, 1, 24'hFFFFFF, 1, 1, 24'hFFFFFF, 0, 0, 0, 0, 0);
        vecs[7]  = mkv(1, 1, 24'h000030, 1, 1, 24'h000030, 0, 0, 0, 0, 0);
        vecs[8]  = mkv(1, 1, 24'h000040, 1, 1, 24'h000040, 0, 1, 1, 1, 3);
        vecs[9]  = mkv(1, 0, 24'h0,      1, 0, 24'h0,      0, 0, 0, 0, 3);
        vecs[10] = mkv(0, 0, 24'h0,      0, 0, 24'h0,      0, 0, 0, 0, 3);

        rst = 1'b1; enable = 1'b0; bus.valid_m = 1'b0; bus.data_m_sobel = '0; bus.ready_s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_m", 32'(bus.ready_m), 0);
        chk("rst_valid_s", 32'(bus.valid_s), 0);
        chk("rst_data_s", 32'(bus.data_s), 0);
        chk("rst_tags", {29'd0, bus.sof_s, bus.eol_s, bus.eof_s}, 0);
        chk("rst_edge_count", 32'(edge_count), 0);
        chk("rst_stat_valid", 32'(stat_valid), 0);
        rst = 1'b0;

        // Full-throughput frame, tags and edge statistics.
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].en, vecs[i].vm, vecs[i].d, vecs[i].rs, a);
            chk($sformatf("v%0d_ready_m", i), 32'(bus.ready_m), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_valid_s", i), 32'(bus.valid_s), 32'(vecs[i].vs));
            chk($sformatf("v%0d_stat_valid", i), 32'(stat_valid), 32'(vecs[i].stv));
            chk($sformatf("v%0d_edge_count", i), 32'(edge_count), 32'(vecs[i].ec));
            if (vecs[i].vs) begin
                chk($sformatf("v%0d_data_s", i), 32'(bus.data_s), 32'(vecs[i].dat));
                chk($sformatf("v%0d_tags", i), {29'd0, bus.sof_s, bus.eol_s, bus.eof_s},
                    {29'd0, vecs[i].sof, vecs[i].eol, vecs[i].eof});
            end
        end
        rx_q.delete();

        // Sink stall mid-stream: two pixels buffered, then ready_m drops.
        cyc(1, 0, 24'h0, 1, a);
        acc_n = 0;
        c = 0;
        while (acc_n < 8 && c < 100) begin
            cyc(1, 1, 24'h100 + 24'(acc_n), !(c >= 2 && c < 7), a);
            if (a) acc_n++;
            if (c == 2) chk("stall_ready_m_drop", 32'(bus.ready_m), 0);
            if (c == 4) begin
                chk("stall_ready_m_held", 32'(bus.ready_m), 0);
                chk("stall_valid_s", 32'(bus.valid_s), 1);
                chk("stall_data_s", 32'(bus.data_s), 32'h101);
            end
            if (c == 6) chk("stall_accepted", 32'(acc_n), 3);
            c++;
        end
        chk("stall_frame_done", 32'(acc_n), 8);
        repeat (3) cyc(1, 0, 24'h0, 1, a);
        for (int i = 0; i < 8; i++) exp_q.push_back(mkp(24'h100 + 24'(i), i));
        check_rx("stall");
        chk("stall_edge_count", 32'(edge_count), 0);

        // Enable falls after px2: frame completes, then IDLE.
        for (int i = 0; i < 8; i++) begin
            d = (i == 3 || i == 6) ? 24'hFFFFFF : 24'h200 + 24'(i);
            cyc(i < 3, 1, d, 1, a);
            chk($sformatf("stop_accept%0d", i), 32'(a), 1);
            exp_q.push_back(mkp(d, i));
        end
        chk("stop_idle_ready_m", 32'(bus.ready_m), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 24'hBAD, 1, a);
            chk($sformatf("stop_idle_hold%0d", i), 32'(bus.ready_m), 0);
        end
        chk("stop_edge_count", 32'(edge_count), 2);
        check_rx("stop");
        cyc(1, 0, 24'h0, 1, a);
        cyc(1, 1, 24'h300, 1, a);
        chk("reenable_accept", 32'(a), 1);
        cyc(1, 0, 24'h0, 1, a);
        exp_q.push_back(mkp(24'h300, 0));
        check_rx("reenable");

        // Reset with two pixels buffered.
        for (int k = 1; k <= 4; k++) cyc(1, 1, 24'h300 + 24'(k), 1, a);
        cyc(1, 1, 24'h305, 0, a);
        chk("prerst_accept", 32'(a), 1);
        chk("prerst_ready_m", 32'(bus.ready_m), 0);
        chk("prerst_data_s", 32'(bus.data_s), 32'h304);
        rst = 1'b1;
        cyc(1, 0, 24'h0, 0, a);
        rst = 1'b0;
        chk("midrst_valid_s", 32'(bus.valid_s), 0);
        chk("midrst_ready_m", 32'(bus.ready_m), 0);
        chk("midrst_edge_count", 32'(edge_count), 0);
        chk("midrst_data_s", 32'(bus.data_s), 0);
        for (int k = 1; k <= 3; k++) exp_q.push_back(mkp(24'h300 + 24'(k), k));
        cyc(1, 0, 24'h0, 1, a);
        check_rx("prerst");
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 24'h400 + 24'(i), 1, a);
            chk($sformatf("restart_accept%0d", i), 32'(a), 1);
            exp_q.push_back(mkp(24'h400 + 24'(i), i));
        end
        repeat (3) cyc(1, 0, 24'h0, 1, a);
        check_rx("restart");

        // Random valid/ready, three frames against the scoreboard.
        stat_n = 0;
        stat_q.delete();
        cnt = 0;
        c = 0;
        edges = '0;
        while (cnt < 24 && c < 3000) begin
            vm = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 1) != 0) ? 24'hFFFFFF : 24'($urandom);
            cyc(1, vm, d, rs, a);
            if (a) begin
                exp_q.push_back(mkp(d, cnt));
                if (d == 24'hFFFFFF) edges = edges + 1'b1;
                if (cnt % 8 == 7) begin
                    exp_ec_q.push_back(edges);
                    edges = '0;
                end
                cnt++;
            end
            c++;
        end
        chk("rand_pixels_accepted", 32'(cnt), 24);
        repeat (6) cyc(1, 0, 24'h0, 1, a);
        check_rx("rand");
        chk("rand_stat_pulses", 32'(stat_n), 3);
        for (int i = 0; i < exp_ec_q.size() && i < stat_q.size(); i++)
            chk($sformatf("rand_edge_count%0d", i), 32'(stat_q[i]), 32'(exp_ec_q[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
